// File: rtl/ring_seq_ctrl.sv
// Sequencer for the one-hot character-select ring feeding the ASCII name coder.
// Walks a programmable-length ring with start/abort, loop mode and valid/ready stalling.
module ring_seq_ctrl #(
    parameter int unsigned N  = 16,
    parameter int unsigned PW = 4,
    parameter int unsigned CW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          abort,
    input  logic          loop_en,
    input  logic [PW-1:0] len_m1,
    input  logic          char_ready,
    output logic [N-1:0]  sel,
    output logic [PW-1:0] pos,
    output logic          char_valid,
    output logic          busy,
    output logic          done,
    output logic          wrap,
    output logic [CW-1:0] pass_cnt
);

    localparam logic [PW-1:0] LAST_IDX  = PW'(N - 1);
    localparam logic [N-1:0]  SEL_FIRST = N'(1);
    localparam logic [CW-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  sel_nxt;
    logic [PW-1:0] pos_nxt;
    logic          char_valid_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          wrap_nxt;
    logic [CW-1:0] pass_cnt_nxt;
    logic [PW-1:0] len_lat, len_lat_nxt;
    logic          loop_lat, loop_lat_nxt;

    logic [PW-1:0] len_clamped;
    logic [CW-1:0] pass_inc;
    logic          xfer;
    logic          at_last;

    // Lengths beyond the ring are clamped to its last position.
    assign len_clamped = (32'(len_m1) >= N) ? LAST_IDX : len_m1;
    assign pass_inc    = (pass_cnt == CNT_MAX) ? pass_cnt : pass_cnt + CW'(1);
    assign xfer        = char_valid & char_ready;
    assign at_last     = (pos == len_lat);

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            sel        <= '0;
            pos        <= '0;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
            pass_cnt   <= '0;
            len_lat    <= '0;
            loop_lat   <= 1'b0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            pos        <= pos_nxt;
            char_valid <= char_valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            wrap       <= wrap_nxt;
            pass_cnt   <= pass_cnt_nxt;
            len_lat    <= len_lat_nxt;
            loop_lat   <= loop_lat_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        pos_nxt        = pos;
        char_valid_nxt = char_valid;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        wrap_nxt       = 1'b0;
        pass_cnt_nxt   = pass_cnt;
        len_lat_nxt    = len_lat;
        loop_lat_nxt   = loop_lat;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt      = S_RUN;
                    len_lat_nxt    = len_clamped;
                    loop_lat_nxt   = loop_en;
                    pass_cnt_nxt   = '0;
                    sel_nxt        = SEL_FIRST;
                    pos_nxt        = '0;
                    char_valid_nxt = 1'b1;
                    busy_nxt       = 1'b1;
                end
            end

            S_RUN: begin
                if (abort) begin
                    // A transfer coinciding with abort is consumed but not credited.
                    state_nxt      = S_IDLE;
                    sel_nxt        = '0;
                    pos_nxt        = '0;
                    char_valid_nxt = 1'b0;
                    busy_nxt       = 1'b0;
                end else if (xfer) begin
                    if (!at_last) begin
                        sel_nxt = {sel[N-2:0], sel[N-1]};
                        pos_nxt = pos + PW'(1);
                    end else if (loop_lat) begin
                        sel_nxt      = SEL_FIRST;
                        pos_nxt      = '0;
                        wrap_nxt     = 1'b1;
                        pass_cnt_nxt = pass_inc;
                    end else begin
                        state_nxt      = S_DONE;
                        done_nxt       = 1'b1;
                        pass_cnt_nxt   = pass_inc;
                        sel_nxt        = '0;
                        pos_nxt        = '0;
                        char_valid_nxt = 1'b0;
                        busy_nxt       = 1'b0;
                    end
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt      = S_IDLE;
                sel_nxt        = '0;
                pos_nxt        = '0;
                char_valid_nxt = 1'b0;
                busy_nxt       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ring_seq_ctrl.sv
// Bench for ring_seq_ctrl: directed scenarios plus random traffic on a 16- and a 12-position ring,
// checked against a transfer-count reference model.
module tb_ring_seq_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        loop_en = 1'b0;
    logic [3:0]  len_m1 = '0;
    logic        char_ready = 1'b0;

    logic [15:0] sel_a;
    logic [3:0]  pos_a;
    logic        cv_a, busy_a, done_a, wrap_a;
    logic [7:0]  pc_a;
    logic [11:0] sel_b;
    logic [3:0]  pos_b;
    logic        cv_b, busy_b, done_b, wrap_b;
    logic [7:0]  pc_b;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0=idle 1=run 2=done; progress kept as total credited transfers.
    int ph[2];
    int mlen[2];
    int mxfer[2];
    bit mloop[2];
    bit mwrap[2];

    ring_seq_ctrl #(.N(16), .PW(4), .CW(8)) dut_a (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .loop_en(loop_en),
        .len_m1(len_m1), .char_ready(char_ready), .sel(sel_a), .pos(pos_a),
        .char_valid(cv_a), .busy(busy_a), .done(done_a), .wrap(wrap_a), .pass_cnt(pc_a)
    );

    ring_seq_ctrl #(.N(12), .PW(4), .CW(8)) dut_b (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .loop_en(loop_en),
        .len_m1(len_m1), .char_ready(char_ready), .sel(sel_b), .pos(pos_b),
        .char_valid(cv_b), .busy(busy_b), .done(done_b), .wrap(wrap_b), .pass_cnt(pc_b)
    );

    always #5 CLK = ~CLK;

    function automatic int ring_n(input int i);
        return (i == 0) ? 16 : 12;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = 0; mlen[i] = 0; mxfer[i] = 0; mloop[i] = 1'b0; mwrap[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int lm;
        for (int i = 0; i < 2; i++) begin
            mwrap[i] = 1'b0;
            case (ph[i])
                0: if (start && !abort) begin
                    lm       = int'(len_m1);
                    mlen[i]  = (lm >= ring_n(i)) ? ring_n(i) - 1 : lm;
                    mloop[i] = loop_en;
                    mxfer[i] = 0;
                    ph[i]    = 1;
                end
                1: if (abort) begin
                    ph[i] = 0;
                end else if (char_ready) begin
                    mxfer[i]++;
                    if (mxfer[i] % (mlen[i] + 1) == 0) begin
                        if (mloop[i]) mwrap[i] = 1'b1;
                        else          ph[i] = 2;
                    end
                end
                default: ph[i] = 0;
            endcase
        end
    endtask

    task automatic check_all();
        int len_tot, p, pc;
        logic [31:0] e_sel;
        bit run;
        for (int i = 0; i < 2; i++) begin
            len_tot = mlen[i] + 1;
            p       = mxfer[i] % len_tot;
            pc      = mxfer[i] / len_tot;
            if (pc > 255) pc = 255;
            run     = (ph[i] == 1);
            e_sel   = run ? (32'd1 << p) : 32'd0;
            if (i == 0) begin
                check_eq("sel_n16",  32'(sel_a),  e_sel);
                check_eq("pos_n16",  32'(pos_a),  run ? 32'(p) : 32'd0);
                check_eq("cv_n16",   32'(cv_a),   32'(run));
                check_eq("busy_n16", 32'(busy_a), 32'(run));
                check_eq("done_n16", 32'(done_a), 32'(ph[i] == 2));
                check_eq("wrap_n16", 32'(wrap_a), 32'(mwrap[i]));
                check_eq("pass_n16", 32'(pc_a),   32'(pc));
            end else begin
                check_eq("sel_n12",  32'(sel_b),  e_sel);
                check_eq("pos_n12",  32'(pos_b),  run ? 32'(p) : 32'd0);
                check_eq("cv_n12",   32'(cv_b),   32'(run));
                check_eq("busy_n12", 32'(busy_b), 32'(run));
                check_eq("done_n12", 32'(done_b), 32'(ph[i] == 2));
                check_eq("wrap_n12", 32'(wrap_b), 32'(mwrap[i]));
                check_eq("pass_n12", 32'(pc_b),   32'(pc));
            end
        end
    endtask

    // One clock: drive on the falling edge, update the model on the rising edge, compare just after.
    task automatic cycle(input logic s, input logic a, input logic le,
                         input logic [3:0] lm, input logic cr);
        @(negedge CLK);
        start = s; abort = a; loop_en = le; len_m1 = lm; char_ready = cr;
        @(posedge CLK);
        model_step();
        #1;
        check_all();
    endtask

    task automatic run_cycles(input int n, input logic cr);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 4'd0, cr);
    endtask

    // Reset asserted between edges must clear outputs before the next rising edge.
    task automatic mid_reset();
        @(negedge CLK);
        start = 1'b0; abort = 1'b0; loop_en = 1'b0; len_m1 = '0; char_ready = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        mid_reset();

        // Full single pass, 16 characters (12 on the small ring)
        cycle(1'b1, 1'b0, 1'b0, 4'd15, 1'b1);
        run_cycles(18, 1'b1);

        // Backpressure at position 2
        cycle(1'b1, 1'b0, 1'b0, 4'd3, 1'b1);
        run_cycles(2, 1'b1);
        run_cycles(3, 1'b0);
        run_cycles(4, 1'b1);

        // Looping walk of length 3, then abort
        cycle(1'b1, 1'b0, 1'b1, 4'd2, 1'b1);
        run_cycles(9, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        run_cycles(1, 1'b0);

        // Abort together with the final transfer of a single pass
        cycle(1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
        run_cycles(1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        run_cycles(2, 1'b1);

        // Start with abort in idle is dropped
        cycle(1'b1, 1'b1, 1'b0, 4'd5, 1'b1);
        run_cycles(2, 1'b1);

        // Async reset at position 7
        cycle(1'b1, 1'b0, 1'b0, 4'd15, 1'b1);
        run_cycles(7, 1'b1);
        mid_reset();

        // Start pulses during run and done have no effect
        cycle(1'b1, 1'b0, 1'b0, 4'd2, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 4'd9, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 4'd7, 1'b1);
        run_cycles(1, 1'b1);

        // Length one, single pass
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        run_cycles(3, 1'b1);

        // Length one, looping, long enough to saturate the pass counter
        cycle(1'b1, 1'b0, 1'b1, 4'd0, 1'b1);
        run_cycles(300, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

        // Random traffic with occasional asynchronous resets
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                mid_reset();
            end else begin
                cycle(1'b0 == ($urandom_range(0, 3) != 0),
                      1'b0 == ($urandom_range(0, 39) != 0),
                      1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)),
                      1'b0 == ($urandom_range(0, 3) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ring_seq_ctrl.md
Name: ring_seq_ctrl

Overview:
- Sequencer for the one-hot character-select ring that feeds the ASCII name coder.
- Replaces the free-running shift ring with a controlled walk:
  - start/abort control.
  - Programmable sequence length.
  - Single-pass or looping mode.
  - valid/ready handshake, so a downstream character consumer (printer/UART) can stall the sequence.
- Its one-hot output connects directly to the coder's select input.

Parameters:
- N, 16, number of one-hot select positions (characters in the name).
- PW, 4, width of position/length fields; must satisfy 2**PW >= N.
- CW, 8, width of completed-pass counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous active-high reset.
- start  input  1  begin a sequence; sampled only in IDLE.
- abort  input  1  terminate sequence; return to IDLE.
- loop_en  input  1  1 = wrap and repeat; 0 = single pass. Latched at start.
- len_m1  input  PW  last position index (sequence length minus 1). Latched at start; values >= N clamp to N-1.
- char_ready  input  1  downstream accepts the current character.
- sel  output  N  one-hot select, bit i = position i; all-zero when not RUN.
- pos  output  PW  current position index.
- char_valid  output  1  sel is presenting a character.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a single pass completes.
- wrap  output  1  one-cycle pulse when a looping pass wraps to position 0.
- pass_cnt  output  CW  completed passes since the last start; saturates at 2**CW-1.

Behaviour:
- One clock, CLK. Reset is asynchronous and active-high on RST.
- All outputs are registered.
- RST asserted (any time, including mid-sequence): immediately sel=0, pos=0, char_valid=0, busy=0, done=0, wrap=0, pass_cnt=0, state=IDLE, latched len/loop=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k (abort=0):
  - Latch len_m1 (clamped) and loop_en; clear pass_cnt.
  - After edge k: state=RUN, pos=0, sel=1, char_valid=1, busy=1.
  - Latency is one cycle from start to first character.
- IDLE, start=1 and abort=1 in the same cycle: abort wins; stay in IDLE.
- start is ignored in RUN and DONE.
- RUN, char_valid & char_ready (a transfer):
  - pos < len_lat: pos+1; sel rotates one place toward higher index.
  - pos == len_lat, loop=1: pos=0, sel=1, wrap=1 for one cycle, pass_cnt+1 (saturating); stay in RUN.
  - pos == len_lat, loop=0: state=DONE, pass_cnt+1, sel=0, char_valid=0, busy=0.
- RUN, char_ready=0: hold pos and sel unchanged; char_valid stays 1 (valid never drops without a transfer except on abort/RST).
- RUN, abort=1: next state IDLE, sel=0, char_valid=0, busy=0, no done pulse, pass_cnt holds. If a transfer also occurs that cycle, it counts as consumed but does not increment pass_cnt or pulse wrap/done.
- DONE: done=1 for exactly one cycle, then IDLE. start during DONE is ignored.
- len_m1=0:
  - Single pass: one character, then DONE.
  - Looping: wrap pulses on every transfer.
- sel is one-hot exactly while RUN and all-zero otherwise. pos equals the index of the set bit in sel.
- No combinational path from inputs to outputs.

Test Plan:
- Reset and basic single pass:
  - Stimulus: RST pulse mid-cycle, then start with len_m1=15, loop_en=0, char_ready=1.
  - Response: sel walks 0x0001..0x8000 over 16 cycles; done pulses one cycle later; pass_cnt=1; busy low afterward.
- Backpressure:
  - Stimulus: len_m1=3, char_ready low for 3 cycles at pos=2.
  - Response: sel=0x0004 and char_valid=1 held for 3 cycles; the full pass takes 4+3 cycles; done pulses once.
- Loop and wrap:
  - Stimulus: len_m1=2, loop_en=1, char_ready=1 for 10 cycles.
  - Response: pos sequence 0,1,2,0,1,2,0,1,2,0; wrap pulses after each 2→0; pass_cnt=3.
- Abort with simultaneous events:
  - Stimulus: abort together with the final transfer (pos=len_lat, single pass).
  - Response: IDLE next cycle; no done pulse; pass_cnt unchanged; sel=0.
  - Stimulus: start together with abort in IDLE.
  - Response: stays in IDLE.
- Async reset mid-run and clamp:
  - Stimulus: RST asserted between edges at pos=7.
  - Response: outputs zero before the next edge.
  - Stimulus: restart with len_m1=15 and N=12.
  - Response: clamps to position 11; done follows the sel=0x800 transfer.
- Ignored start and short length:
  - Stimulus: start pulsed during RUN and during DONE.
  - Response: no effect.
  - Stimulus: len_m1=0, loop_en=0.
  - Response: a single sel=0x0001 cycle, then done.
